// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared definitions for the registered code decoder:
//   - in_mode encodings (one-hot, thermometer, inverted one-hot, reserved)
//   - pipeline state encoding for the output/skid register pair
//   - decode_code(): computes {err, vec} for a code/mode pair at a given
//     output width. The result is sized for the largest legal output
//     (2**8 bits); callers keep the low out_w bits.
package decoder_pkg;

    localparam int unsigned MAX_IN_W  = 8;
    localparam int unsigned MAX_OUT_W = 256;

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_INVHOT = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Encoding mirrors {oreg_v, sreg_v}: EMPTY (0,0), ONE (1,0), FULL (1,1).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } pipe_state_e;

    // Bit MAX_OUT_W of the result is the error flag, the rest is the vector.
    // Out-of-range codes and the reserved mode yield an all-zero vector so
    // that no partial pattern (e.g. an inverted one-hot with no hole) leaks.
    function automatic logic [MAX_OUT_W:0] decode_code(
        input logic [MAX_IN_W-1:0] code,
        input logic [1:0]          mode,
        input int unsigned         out_w
    );
        logic [MAX_OUT_W-1:0] vec;
        logic                 err;
        int unsigned          k;
        vec = '0;
        err = 1'b0;
        k   = {24'd0, code};
        if ((mode == MODE_RSVD) || (k >= out_w)) begin
            err = 1'b1;
        end else begin
            for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
                if (i < out_w) begin
                    case (mode)
                        MODE_ONEHOT: vec[i] = (i == k);
                        MODE_THERM:  vec[i] = (i <= k);
                        MODE_INVHOT: vec[i] = (i != k);
                        default:     vec[i] = 1'b0;
                    endcase
                end
            end
        end
        return {err, vec};
    endfunction

endpackage

// File: rtl/decoder_core_n.sv
// decoder_core_n
// Purely combinational N-to-M decoder wrapping decoder_pkg::decode_code.
// Ports:
//   code  [IN_W-1:0]  code to decode (unsigned)
//   mode  [1:0]       decode mode (see decoder_pkg MODE_*)
//   vec   [OUT_W-1:0] decoded vector
//   err               code >= OUT_W or reserved mode
module decoder_core_n
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W  = 6,
    parameter int unsigned OUT_W = 64
) (
    input  logic [IN_W-1:0]  code,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] vec,
    output logic             err
);

    logic [MAX_OUT_W:0]   full;
    logic [MAX_OUT_W-1:0] unused_hi;

    always_comb begin
        full      = decode_code(MAX_IN_W'(code), mode, OUT_W);
        vec       = full[OUT_W-1:0];
        err       = full[MAX_OUT_W];
        // Bits above OUT_W are always zero; folded here so nothing dangles.
        unused_hi = full[MAX_OUT_W-1:0] >> OUT_W;
    end

endmodule

// File: rtl/decoder_pipe_n.sv
// decoder_pipe_n
// Registered, back-pressurable code decoder with a 2-entry skid buffer.
// Decoding is done before the registers, so the output register (OREG) and
// skid register (SREG) both hold finished {vec, err} results.
// Ports:
//   cpu_clk_50M            clock, rising edge
//   cpu_rst_n              asynchronous active-low reset
//   in_valid / in_ready    request handshake
//   in_code  [IN_W-1:0]    code to decode
//   in_mode  [1:0]         00 one-hot, 01 thermometer, 10 inverted, 11 rsvd
//   out_valid / out_ready  result handshake
//   out_vec  [OUT_W-1:0]   decoded vector
//   out_err                code out of range or reserved mode
module decoder_pipe_n
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W  = 6,
    parameter int unsigned OUT_W = 64
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_vec,
    output logic             out_err
);

    if ((IN_W < 1) || (IN_W > MAX_IN_W) || (OUT_W < 2) || (OUT_W > (1 << IN_W))) begin : g_param_check
        $error("decoder_pipe_n: illegal IN_W/OUT_W combination");
    end

    pipe_state_e      state_q, state_d;
    logic [OUT_W-1:0] oreg_vec_q, oreg_vec_d;
    logic             oreg_err_q, oreg_err_d;
    logic [OUT_W-1:0] sreg_vec_q, sreg_vec_d;
    logic             sreg_err_q, sreg_err_d;

    logic [OUT_W-1:0] dec_vec;
    logic             dec_err;
    logic             oreg_v;
    logic             sreg_v;
    logic             in_xfer;
    logic             out_xfer;

    decoder_core_n #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .code (in_code),
        .mode (in_mode),
        .vec  (dec_vec),
        .err  (dec_err)
    );

    // in_ready depends only on registered state (plus reset), never on
    // out_ready, so the consumer's ready does not ripple back upstream.
    always_comb begin
        oreg_v    = state_q[1];
        sreg_v    = state_q[0];
        in_ready  = cpu_rst_n & ~sreg_v;
        out_valid = oreg_v;
        out_vec   = oreg_vec_q;
        out_err   = oreg_err_q;
        in_xfer   = in_valid & in_ready;
        out_xfer  = oreg_v & out_ready;
    end

    // Skid control: new results go to OREG when it is empty or draining this
    // cycle, otherwise into SREG; SREG refills OREG when OREG drains.
    always_comb begin
        state_d    = state_q;
        oreg_vec_d = oreg_vec_q;
        oreg_err_d = oreg_err_q;
        sreg_vec_d = sreg_vec_q;
        sreg_err_d = sreg_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d    = ST_ONE;
                    oreg_vec_d = dec_vec;
                    oreg_err_d = dec_err;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    oreg_vec_d = dec_vec;
                    oreg_err_d = dec_err;
                end else if (in_xfer) begin
                    state_d    = ST_FULL;
                    sreg_vec_d = dec_vec;
                    sreg_err_d = dec_err;
                end else if (out_xfer) begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_d    = ST_ONE;
                    oreg_vec_d = sreg_vec_q;
                    oreg_err_d = sreg_err_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and data registers; reset discards everything at once.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q    <= ST_EMPTY;
            oreg_vec_q <= '0;
            oreg_err_q <= 1'b0;
            sreg_vec_q <= '0;
            sreg_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            oreg_vec_q <= oreg_vec_d;
            oreg_err_q <= oreg_err_d;
            sreg_vec_q <= sreg_vec_d;
            sreg_err_q <= sreg_err_d;
        end
    end

endmodule

// File: tb/tb_decoder_pipe_n.sv
// tb_decoder_pipe_n
// Directed bench for decoder_pipe_n: a 6-to-64 instance (A) and a 4-to-10
// instance (B) share clock and reset. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_decoder_pipe_n;

    logic clk;
    logic rst_n;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [5:0]  a_in_code;
    logic [1:0]  a_in_mode;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [63:0] a_out_vec;
    logic        a_out_err;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [3:0]  b_in_code;
    logic [1:0]  b_in_mode;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [9:0]  b_out_vec;
    logic        b_out_err;

    int checks;
    int errors;

    decoder_pipe_n #(.IN_W(6), .OUT_W(64)) dut_a (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .in_code     (a_in_code),
        .in_mode     (a_in_mode),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_vec     (a_out_vec),
        .out_err     (a_out_err)
    );

    decoder_pipe_n #(.IN_W(4), .OUT_W(10)) dut_b (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_code     (b_in_code),
        .in_mode     (b_in_mode),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_vec     (b_out_vec),
        .out_err     (b_out_err)
    );

    // 50 MHz clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Drives the A-instance request and consumer-ready inputs.
    task automatic applyStimulus(input logic v, input logic [5:0] code,
                                 input logic [1:0] mode, input logic ordy);
        a_in_valid  = v;
        a_in_code   = code;
        a_in_mode   = mode;
        a_out_ready = ordy;
    endtask

    // One comparison: counts it, and counts/reports it on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepNeg();
        @(negedge clk);
    endtask

    // Directed sequence.
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        applyStimulus(1'b0, 6'd0, 2'b00, 1'b1);
        b_in_valid  = 1'b0;
        b_in_code   = 4'd0;
        b_in_mode   = 2'b00;
        b_out_ready = 1'b1;

        // Reset values.
        #2 rst_n = 1'b0;
        #2;
        checkOutput("rst_in_ready_low", 64'(a_in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(a_out_valid), 64'd0);
        checkOutput("rst_out_vec", a_out_vec, 64'd0);
        checkOutput("rst_out_err", 64'(a_out_err), 64'd0);
        stepNeg();
        stepNeg();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 64'(a_in_ready), 64'd1);

        // Single one-hot request, code 5.
        stepNeg();
        applyStimulus(1'b1, 6'd5, 2'b00, 1'b1);
        stepNeg();
        checkOutput("oh5_valid", 64'(a_out_valid), 64'd1);
        checkOutput("oh5_vec", a_out_vec, 64'h20);
        checkOutput("oh5_err", 64'(a_out_err), 64'd0);
        applyStimulus(1'b0, 6'd0, 2'b00, 1'b1);
        stepNeg();
        checkOutput("oh5_valid_one_cycle", 64'(a_out_valid), 64'd0);

        // Back-to-back thermometer codes 0, 63, 31.
        applyStimulus(1'b1, 6'd0, 2'b01, 1'b1);
        stepNeg();
        checkOutput("th0_vec", a_out_vec, 64'h1);
        checkOutput("th0_in_ready", 64'(a_in_ready), 64'd1);
        applyStimulus(1'b1, 6'd63, 2'b01, 1'b1);
        stepNeg();
        checkOutput("th63_vec", a_out_vec, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("th63_valid", 64'(a_out_valid), 64'd1);
        checkOutput("th63_in_ready", 64'(a_in_ready), 64'd1);
        applyStimulus(1'b1, 6'd31, 2'b01, 1'b1);
        stepNeg();
        checkOutput("th31_vec", a_out_vec, 64'h0000_0000_FFFF_FFFF);
        checkOutput("th31_in_ready", 64'(a_in_ready), 64'd1);
        applyStimulus(1'b0, 6'd0, 2'b00, 1'b1);
        stepNeg();
        checkOutput("th_drain_valid", 64'(a_out_valid), 64'd0);

        // Back-pressure: codes 3, 4, 7 with out_ready low for three cycles.
        applyStimulus(1'b1, 6'd3, 2'b00, 1'b0);
        stepNeg();
        checkOutput("bp3_vec", a_out_vec, 64'h8);
        checkOutput("bp3_in_ready", 64'(a_in_ready), 64'd1);
        applyStimulus(1'b1, 6'd4, 2'b00, 1'b0);
        stepNeg();
        checkOutput("bp_full_in_ready", 64'(a_in_ready), 64'd0);
        checkOutput("bp_hold_vec1", a_out_vec, 64'h8);
        applyStimulus(1'b1, 6'd7, 2'b00, 1'b0);
        stepNeg();
        checkOutput("bp_full_in_ready2", 64'(a_in_ready), 64'd0);
        checkOutput("bp_hold_vec2", a_out_vec, 64'h8);
        checkOutput("bp_hold_valid", 64'(a_out_valid), 64'd1);
        applyStimulus(1'b1, 6'd7, 2'b00, 1'b1);
        stepNeg();
        checkOutput("bp4_vec", a_out_vec, 64'h10);
        checkOutput("bp4_in_ready", 64'(a_in_ready), 64'd1);
        stepNeg();
        checkOutput("bp7_vec", a_out_vec, 64'h80);
        checkOutput("bp7_valid", 64'(a_out_valid), 64'd1);
        applyStimulus(1'b0, 6'd0, 2'b00, 1'b1);
        stepNeg();
        checkOutput("bp_drain_valid", 64'(a_out_valid), 64'd0);

        // Reserved mode, then an in-range inverted one-hot.
        applyStimulus(1'b1, 6'd2, 2'b11, 1'b1);
        stepNeg();
        checkOutput("rsvd_vec", a_out_vec, 64'd0);
        checkOutput("rsvd_err", 64'(a_out_err), 64'd1);
        checkOutput("rsvd_valid", 64'(a_out_valid), 64'd1);
        applyStimulus(1'b1, 6'd0, 2'b10, 1'b1);
        stepNeg();
        checkOutput("inv0_vec", a_out_vec, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("inv0_err", 64'(a_out_err), 64'd0);
        applyStimulus(1'b0, 6'd0, 2'b00, 1'b1);
        stepNeg();

        // Narrow instance: 4-bit code, 10-bit output.
        b_in_valid = 1'b1;
        b_in_code  = 4'd12;
        b_in_mode  = 2'b10;
        stepNeg();
        checkOutput("b_inv12_vec", 64'(b_out_vec), 64'd0);
        checkOutput("b_inv12_err", 64'(b_out_err), 64'd1);
        b_in_code = 4'd9;
        stepNeg();
        checkOutput("b_inv9_vec", 64'(b_out_vec), 64'h1FF);
        checkOutput("b_inv9_err", 64'(b_out_err), 64'd0);
        b_in_code = 4'd10;
        b_in_mode = 2'b01;
        stepNeg();
        checkOutput("b_th10_vec", 64'(b_out_vec), 64'd0);
        checkOutput("b_th10_err", 64'(b_out_err), 64'd1);
        b_in_code = 4'd9;
        stepNeg();
        checkOutput("b_th9_vec", 64'(b_out_vec), 64'h3FF);
        b_in_valid = 1'b0;
        stepNeg();

        // Reset while FULL, then a fresh request.
        applyStimulus(1'b1, 6'd1, 2'b00, 1'b0);
        stepNeg();
        applyStimulus(1'b1, 6'd2, 2'b00, 1'b0);
        stepNeg();
        checkOutput("pre_rst_full", 64'(a_in_ready), 64'd0);
        applyStimulus(1'b0, 6'd0, 2'b00, 1'b0);
        #5 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(a_out_valid), 64'd0);
        checkOutput("midrst_vec", a_out_vec, 64'd0);
        checkOutput("midrst_in_ready", 64'(a_in_ready), 64'd0);
        stepNeg();
        rst_n = 1'b1;
        #1;
        checkOutput("postrst_in_ready", 64'(a_in_ready), 64'd1);
        checkOutput("postrst_valid", 64'(a_out_valid), 64'd0);
        applyStimulus(1'b1, 6'd6, 2'b00, 1'b1);
        stepNeg();
        checkOutput("postrst_vec", a_out_vec, 64'h40);
        checkOutput("postrst_req_valid", 64'(a_out_valid), 64'd1);
        applyStimulus(1'b0, 6'd0, 2'b00, 1'b1);
        stepNeg();
        checkOutput("postrst_no_stale", 64'(a_out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder_pipe_n.md
# decoder_pipe_n

Parametrised, registered N-to-M code decoder with a valid/ready handshake and a 2-entry skid buffer, generalising the fixed combinational 6-to-64 one-hot decoder. Produces one-hot, thermometer or inverted one-hot vectors selected per transaction. Flags codes outside the output range. Sits between the ID stage and consumers such as the CP0/TLB index select and the byte-lane and register-file write-enable generators, where a registered, back-pressurable decode breaks the critical path.

## Interface
- IN_W, 6, code width in bits; 1..8.
- OUT_W, 64, output vector width; 2 ≤ OUT_W ≤ 2**IN_W (elaboration error otherwise).
- cpu_clk_50M  input  1  sole clock, rising edge.
- cpu_rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_code  input  IN_W  code to decode, unsigned.
- in_mode  input  2  00 one-hot, 01 thermometer, 10 inverted one-hot, 11 reserved.
- out_valid  output  1  out_vec/out_err valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_vec  output  OUT_W  decoded vector.
- out_err  output  1  code ≥ OUT_W, or reserved mode.

## Operation
- Decode function f(code, mode), with k = code:
  - one-hot: bit k = 1, all others 0.
  - thermometer: bits 0..k = 1, others 0.
  - inverted one-hot: all bits 1 except bit k = 0.
- Out of range (k ≥ OUT_W, any mode):
  - out_vec all 0, out_err = 1.
  - Inverted one-hot also gives all 0; no partial vector is ever emitted.
- Reserved mode 11: out_vec all 0, out_err = 1.
- No X is ever driven on out_vec; there is no default-X branch.
- A transfer occurs on the input side when in_valid & in_ready, and on the output side when out_valid & out_ready.
- Storage: output register (OREG) plus one skid register (SREG). Decode happens before the registers, so both hold decoded results.
- States (encoded by oreg_v, sreg_v):
  - EMPTY (0,0).
  - ONE (1,0).
  - FULL (1,1).
- in_ready = !sreg_v, forced 0 while cpu_rst_n is low.
- Transitions:
  - EMPTY + in xfer → ONE, OREG loaded.
  - ONE + in xfer + out xfer → ONE, OREG replaced.
  - ONE + in xfer, no out xfer → FULL, SREG loaded.
  - ONE + out xfer only → EMPTY.
  - FULL + out xfer → ONE, OREG ← SREG. No input is accepted in FULL because in_ready = 0.
- Ordering is strictly FIFO. No request is dropped or duplicated.
- in_code and in_mode are sampled only on an input transfer.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - out_valid = 0, out_vec = 0, out_err = 0.
  - Both valid flags cleared, SREG data = 0.
  - in_ready = 1 from the first edge after deassertion.
- Latency: an input accepted at edge t is visible on out_vec with out_valid = 1 after edge t (one cycle).
- Throughput: one transfer per cycle while out_ready stays high.
- Back-pressure:
  - out_ready low for one cycle with in_valid high fills SREG; in_ready drops in the next cycle.
  - in_ready is a registered function of state; there is no combinational path from out_ready to in_ready.
- While out_valid = 1 and out_ready = 0, out_vec and out_err hold stable.
- Reset mid-operation: contents of both registers are discarded immediately. No output transfer completes in the reset cycle.

## Structure
- Shared package decoder_pkg holds:
  - the in_mode localparams MODE_ONEHOT, MODE_THERM, MODE_INVHOT, MODE_RSVD;
  - the function computing f(code, mode, OUT_W) → {err, vec}.
- One sub-module, decoder_core_n: purely combinational, parametrised IN_W/OUT_W, wraps the package function.
- decoder_pipe_n contains the handshake/skid control and the two registers.

## Test plan
- Reset, then a single request code = 5, mode 00, out_ready = 1 → one cycle later out_vec = 64'h20, out_err = 0, out_valid for exactly one cycle.
- Back-to-back codes 0, 63, 31 in mode 01 with out_ready = 1 → consecutive outputs 64'h1, all ones, 64'h0000_0000_FFFF_FFFF; in_ready stays 1.
- Codes 3, 4, 7 with out_ready held low for 3 cycles:
  - state reaches FULL and in_ready = 0;
  - the third request is held at the input;
  - after release, outputs appear in order 3, 4, 7 with no loss.
- IN_W = 4, OUT_W = 10:
  - code 12 in mode 10 → out_vec = 0, out_err = 1;
  - code 9 in mode 10 → 10'b01_1111_1111.
- Mode 11 with code 2 → out_vec = 0, out_err = 1.
- Reset asserted while in FULL → out_valid = 0 and out_vec = 0 immediately; first post-reset request decodes correctly.
